// File: rtl/pool2x2.sv
// pool2x2: 2x2 stride-2 pooling of a 6x6 raster frame into a 3x3 raster frame.
// Ports: clk, rst_n (async active-low), in_st frame-start strobe, din 16-bit
// input word; dout 16-bit pooled word, out_st pooled-frame strobe, busy.
// Build option: define POOL_AVG_EN for average pooling, default is max pooling.
module pool2x2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_st,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        out_st,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
`ifdef POOL_AVG_EN
  localparam int BW = 18;
`else
  localparam int BW = 16;
`endif
  state_t state_q, state_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [3:0] ecnt_q, ecnt_d;
  logic [15:0] dout_q, dout_d;
  logic out_st_q, out_st_d;
  logic [BW-1:0] lbuf_q [3];
  logic [15:0] res_q [9];
  logic [1:0] j;
  logic [3:0] ridx;
  logic [BW-1:0] first, comb;
  logic [15:0] pooled;
  assign j = col_q[2:1];
  assign ridx = 4'(row_q[2:1]) * 4'd3 + 4'(j);
`ifdef POOL_AVG_EN
  assign first = {2'b00, din};
  assign comb = lbuf_q[j] + first;
  assign pooled = comb[17:2];
`else
  assign first = din;
  assign comb = (din > lbuf_q[j]) ? din : lbuf_q[j];
  assign pooled = comb;
`endif
  // Window storage carries no reset: it is always rewritten before a frame emits.
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      lbuf_q[j] <= (!row_q[0] && !col_q[0]) ? first : comb;
      if (row_q[0] && col_q[0]) res_q[ridx] <= pooled;
    end
  end
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    ecnt_d = ecnt_q;
    dout_d = dout_q;
    out_st_d = 1'b0;
    case (state_q)
      IDLE: if (in_st) begin
        state_d = LOAD;
        row_d = 3'd0;
        col_d = 3'd0;
      end
      LOAD: begin
        col_d = (col_q == 3'd5) ? 3'd0 : col_q + 3'd1;
        row_d = (col_q == 3'd5) ? row_q + 3'd1 : row_q;
        if (row_q == 3'd5 && col_q == 3'd5) begin
          state_d = EMIT;
          row_d = 3'd0;
          ecnt_d = 4'd0;
        end
      end
      EMIT: begin
        // Slot 0 raises the strobe; slots 1..9 present result[0..8].
        ecnt_d = ecnt_q + 4'd1;
        out_st_d = (ecnt_q == 4'd0);
        if (ecnt_q != 4'd0) dout_d = res_q[ecnt_q - 4'd1];
        if (ecnt_q == 4'd9) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q <= 3'd0;
      col_q <= 3'd0;
      ecnt_q <= 4'd0;
      dout_q <= 16'h0000;
      out_st_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      ecnt_q <= ecnt_d;
      dout_q <= dout_d;
      out_st_q <= out_st_d;
    end
  end
  assign dout = dout_q;
  assign out_st = out_st_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_pool2x2.sv
// tb_pool2x2: randomized and directed frames checked against a window-level pooling model.
module tb_pool2x2;
  logic clk = 1'b0, rst_n, in_st;
  logic [15:0] din, dout;
  logic out_st, busy;
  int checks = 0, errors = 0;
  logic [15:0] w [36];
  logic [15:0] e [9];
  pool2x2 dut (.clk(clk), .rst_n(rst_n), .in_st(in_st), .din(din), .dout(dout), .out_st(out_st), .busy(busy));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model();
    for (int k = 0; k < 9; k++) begin
      int b, s, m;
      b = (k / 3) * 12 + (k % 3) * 2;
      s = int'(w[b]) + int'(w[b+1]) + int'(w[b+6]) + int'(w[b+7]);
      m = int'(w[b]);
      if (int'(w[b+1]) > m) m = int'(w[b+1]);
      if (int'(w[b+6]) > m) m = int'(w[b+6]);
      if (int'(w[b+7]) > m) m = int'(w[b+7]);
`ifdef POOL_AVG_EN
      e[k] = 16'(s / 4);
`else
      e[k] = 16'(m);
`endif
    end
  endtask
  task automatic fill(input int kind);
    for (int i = 0; i < 36; i++)
      w[i] = (kind == 0) ? 16'(i) : (kind == 1) ? 16'hFFFF : (kind == 2) ? 16'(35 - i) : 16'($urandom);
    model();
  endtask
  // Entered and left on a negedge; mode 1 pulses in_st mid-frame, mode 2 resets at word 20.
  task automatic frame(input int mode);
    in_st = 1'b1;
    din = 16'($urandom);
    @(negedge clk);
    in_st = 1'b0;
    check("busy_load", {15'd0, busy}, 16'd1);
    for (int i = 0; i < 36; i++) begin
      if (mode == 2 && i == 20) begin
        rst_n = 1'b0;
        #1;
        check("rst_dout", dout, 16'h0000);
        check("rst_out_st", {15'd0, out_st}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 50; t++) begin
          din = 16'($urandom);
          @(negedge clk);
          check("abandon_out_st", {15'd0, out_st}, 16'd0);
          check("abandon_dout", dout, 16'h0000);
        end
        return;
      end
      din = w[i];
      in_st = (mode == 1 && i == 10);
      @(negedge clk);
      check("load_out_st", {15'd0, out_st}, 16'd0);
    end
    din = 16'($urandom);
    in_st = 1'b0;
    for (int t = 37; t <= 46; t++) begin
      in_st = (mode == 1 && t == 40);
      @(negedge clk);
      check("out_st", {15'd0, out_st}, {15'd0, t == 37});
      check("busy_emit", {15'd0, busy}, {15'd0, t < 46});
      if (t >= 38) check($sformatf("dout%0d", t - 38), dout, e[t - 38]);
    end
    in_st = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    in_st = 1'b0;
    din = 16'h0;
    #1;
    check("reset_dout", dout, 16'h0000);
    check("reset_out_st", {15'd0, out_st}, 16'd0);
    check("reset_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {15'd0, busy}, 16'd0);
    fill(0);
    frame(0);
    @(negedge clk);
    check("hold_dout", dout, e[8]);
    check("hold_busy", {15'd0, busy}, 16'd0);
    fill(1);
    frame(0);
    fill(0);
    frame(1);
    @(negedge clk);
    check("ignored_out_st", {15'd0, out_st}, 16'd0);
    fill(3);
    frame(2);
    fill(0);
    frame(0);
    fill(2);
    frame(0);
    for (int n = 0; n < 4; n++) begin
      fill(3);
      frame(0);
    end
    repeat (5) @(negedge clk);
    check("final_hold", dout, e[8]);
    check("final_out_st", {15'd0, out_st}, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
